irq_aggregator: RTL



---
 rtl/irq_aggregator_pkg.sv | 20 ++
 rtl/irq_aggregator_prio_enc.sv | 21 ++
 rtl/irq_aggregator.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/irq_aggregator_pkg.sv
// Shared register map, FSM state encoding and VECTOR layout for irq_aggregator.
package irq_aggregator_pkg;

    localparam logic [2:0] ADDR_STATUS  = 3'd0;
    localparam logic [2:0] ADDR_MASK    = 3'd1;
    localparam logic [2:0] ADDR_EDGE    = 3'd2;
    localparam logic [2:0] ADDR_ACK     = 3'd3;
    localparam logic [2:0] ADDR_ACTIVE  = 3'd4;
    localparam logic [2:0] ADDR_VECTOR  = 3'd5;
    localparam logic [2:0] ADDR_HOLDOFF = 3'd6;

    localparam int unsigned VEC_VALID_BIT = 15;

    typedef enum logic [1:0] {
        IDLE,
        ASSERT,
        HOLDOFF
    } irq_state_e;

endpackage

// File: rtl/irq_aggregator_prio_enc.sv
// Fixed-priority encoder: reports the lowest set index of the active vector.
module irq_aggregator_prio_enc #(
    parameter int unsigned N = 8
) (
    input  logic [N-1:0] active_i,
    output logic         valid_o,
    output logic [3:0]   index_o
);

    always_comb begin
        valid_o = 1'b0;
        index_o = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (active_i[i] && !valid_o) begin
                valid_o = 1'b1;
                index_o = 4'(i);
            end
        end
    end

endmodule

// File: rtl/irq_aggregator.sv
// Interrupt aggregator slave: pending/mask/edge registers, priority vector, irq FSM.
// Define IRQ_HOLDOFF_EN to enable the post-acknowledge irq holdoff counter.
module irq_aggregator
    import irq_aggregator_pkg::*;
#(
    parameter int unsigned NUM_SRC        = 8,
    parameter int unsigned HOLDOFF_CYCLES = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [2:0]         address,
    input  logic               chipselect,
    input  logic               write_n,
    input  logic [15:0]        writedata,
    output logic [15:0]        readdata,
    input  logic [NUM_SRC-1:0] irq_src,
    output logic               irq
);

    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic [NUM_SRC-1:0] mask_q, mask_d;
    logic [NUM_SRC-1:0] edge_q, edge_d;
    logic [NUM_SRC-1:0] src_q;
    logic [NUM_SRC-1:0] set_evt, ack_clr, active;
    logic [15:0]        readdata_q, readdata_d;
    logic [15:0]        vector, hold_view;
    logic               irq_q, irq_d;
    logic               wr_stb, vec_valid;
    logic [3:0]         vec_index;
    irq_state_e         state_q, state_d;

`ifdef IRQ_HOLDOFF_EN
    localparam logic [15:0] HOLD_INIT = 16'(HOLDOFF_CYCLES - 1);
    logic [15:0] hold_q, hold_d;
    logic        ack_any;
    assign ack_any   = wr_stb && (address == ADDR_ACK) && (writedata != '0);
    assign hold_view = hold_q;
`else
    logic unused_holdoff;
    assign unused_holdoff = ^{writedata, HOLDOFF_CYCLES};
    assign hold_view      = '0;
`endif

    assign wr_stb = chipselect & ~write_n;
    assign active = pending_q & mask_q;

    irq_aggregator_prio_enc #(.N(NUM_SRC)) u_prio_enc (
        .active_i (active),
        .valid_o  (vec_valid),
        .index_o  (vec_index)
    );

    always_comb begin
        mask_d  = mask_q;
        edge_d  = edge_q;
        ack_clr = '0;
        if (wr_stb && address == ADDR_MASK) mask_d  = writedata[NUM_SRC-1:0];
        if (wr_stb && address == ADDR_EDGE) edge_d  = writedata[NUM_SRC-1:0];
        if (wr_stb && address == ADDR_ACK)  ack_clr = writedata[NUM_SRC-1:0];
        // Edge sources fire on rising edge only; a same-cycle set overrides the ack clear.
        set_evt   = irq_src & ~(edge_q & src_q);
        pending_d = (pending_q & ~ack_clr) | set_evt;
    end

    always_comb begin
        vector                = '0;
        vector[VEC_VALID_BIT] = vec_valid;
        vector[3:0]           = vec_index;
        case (address)
            ADDR_STATUS:  readdata_d = 16'(pending_q);
            ADDR_MASK:    readdata_d = 16'(mask_q);
            ADDR_EDGE:    readdata_d = 16'(edge_q);
            ADDR_ACTIVE:  readdata_d = 16'(active);
            ADDR_VECTOR:  readdata_d = vector;
            ADDR_HOLDOFF: readdata_d = hold_view;
            default:      readdata_d = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
`ifdef IRQ_HOLDOFF_EN
        hold_d  = hold_q;
`endif
        case (state_q)
            IDLE: begin
                if (|active) state_d = ASSERT;
            end
            ASSERT: begin
                if (active == '0) state_d = IDLE;
`ifdef IRQ_HOLDOFF_EN
                if (ack_any) begin
                    state_d = HOLDOFF;
                    hold_d  = HOLD_INIT;
                end
`endif
            end
            HOLDOFF: begin
`ifdef IRQ_HOLDOFF_EN
                if (hold_q == '0) state_d = (|active) ? ASSERT : IDLE;
                else              hold_d  = hold_q - 16'd1;
`else
                state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase
        irq_d = (state_d == ASSERT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q  <= '0;
            mask_q     <= '0;
            edge_q     <= '0;
            src_q      <= '0;
            readdata_q <= '0;
            irq_q      <= 1'b0;
            state_q    <= IDLE;
`ifdef IRQ_HOLDOFF_EN
            hold_q     <= '0;
`endif
        end else begin
            pending_q  <= pending_d;
            mask_q     <= mask_d;
            edge_q     <= edge_d;
            src_q      <= irq_src;
            readdata_q <= readdata_d;
            irq_q      <= irq_d;
            state_q    <= state_d;
`ifdef IRQ_HOLDOFF_EN
            hold_q     <= hold_d;
`endif
        end
    end

    assign readdata = readdata_q;
    assign irq      = irq_q;

endmodule
